// File: rtl/fp16_to_int16.sv
// IEEE-754 binary16 to signed Q(15-FRAC_BITS).FRAC_BITS converter.
// Serial shifter (one bit per cycle) followed by a round-to-nearest-even step.
module fp16_to_int16 #(
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        out_invalid,
  output logic        out_inexact
);

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MAG_W     = 16;
  localparam int unsigned RND_W     = MAG_W + 1;
  localparam int unsigned CNT_W     = 4;
  localparam int          MAX_SHIFT = 12;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t              r_state, w_state;
  logic                r_sign, w_sign;
  logic                r_left, w_left;
  logic [MAG_W-1:0]    r_mag, w_mag;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic                r_guard, w_guard;
  logic                r_sticky, w_sticky;
  logic                r_sat_pre, w_sat_pre;
  logic                r_inv_pre, w_inv_pre;
  logic                r_in_ready, w_in_ready;
  logic                r_out_valid, w_out_valid;
  logic [DATA_W-1:0]   r_data, w_data;
  logic                r_sat, w_sat;
  logic                r_inv, w_inv;
  logic                r_inexact, w_inexact;

  logic [4:0]          w_exp;
  logic [9:0]          w_man;
  int                  w_e_eff, w_k, w_p, w_abs_k;
  logic [CNT_W-1:0]    w_n;
  logic                w_is_nan, w_is_inf, w_is_zero, w_ovf, w_inc;
  logic [RND_W-1:0]    w_rnd, w_neg;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_left      <= 1'b0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_sat_pre   <= 1'b0;
      r_inv_pre   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_sat       <= 1'b0;
      r_inv       <= 1'b0;
      r_inexact   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sign      <= w_sign;
      r_left      <= w_left;
      r_mag       <= w_mag;
      r_cnt       <= w_cnt;
      r_guard     <= w_guard;
      r_sticky    <= w_sticky;
      r_sat_pre   <= w_sat_pre;
      r_inv_pre   <= w_inv_pre;
      r_in_ready  <= w_in_ready;
      r_out_valid <= w_out_valid;
      r_data      <= w_data;
      r_sat       <= w_sat;
      r_inv       <= w_inv;
      r_inexact   <= w_inexact;
    end
  end

  // Next-state, operand decode and result formation
  always_comb begin
    w_state   = r_state;
    w_sign    = r_sign;
    w_left    = r_left;
    w_mag     = r_mag;
    w_cnt     = r_cnt;
    w_guard   = r_guard;
    w_sticky  = r_sticky;
    w_sat_pre = r_sat_pre;
    w_inv_pre = r_inv_pre;
    w_data    = r_data;
    w_sat     = r_sat;
    w_inv     = r_inv;
    w_inexact = r_inexact;

    w_exp     = in_data[14:10];
    w_man     = in_data[9:0];
    w_e_eff   = (w_exp == 5'd0) ? 1 : int'(w_exp);
    w_k       = w_e_eff - 25 + int'(FRAC_BITS);
    w_p       = w_e_eff - 15 + int'(FRAC_BITS);
    w_abs_k   = (w_k < 0) ? -w_k : w_k;
    w_n       = (w_abs_k > MAX_SHIFT) ? CNT_W'(MAX_SHIFT) : CNT_W'(w_abs_k);
    w_is_nan  = (w_exp == 5'd31) && (w_man != 10'd0);
    w_is_inf  = (w_exp == 5'd31) && (w_man == 10'd0);
    w_is_zero = (w_exp == 5'd0) && (w_man == 10'd0);
    // Exactly -2^15 is the only representable value at p=15
    w_ovf     = (w_exp != 5'd31) &&
                ((w_p >= 16) || ((w_p == 15) && !(in_data[15] && (w_man == 10'd0))));

    w_inc     = r_guard & (r_sticky | r_mag[0]);
    w_rnd     = {1'b0, r_mag} + RND_W'(w_inc);
    w_neg     = -w_rnd;

    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sign    = in_data[15];
          w_left    = (w_k > 0);
          w_mag     = MAG_W'({(w_exp != 5'd0), w_man});
          w_cnt     = w_n;
          w_guard   = 1'b0;
          w_sticky  = 1'b0;
          w_sat_pre = 1'b0;
          w_inv_pre = 1'b0;
          w_data    = '0;
          w_sat     = 1'b0;
          w_inv     = 1'b0;
          w_inexact = 1'b0;
          if (w_is_nan) begin
            w_inv_pre = 1'b1;
            w_mag     = '0;
            w_cnt     = '0;
          end else if (w_is_inf || w_ovf) begin
            w_sat_pre = 1'b1;
            w_mag     = '0;
            w_cnt     = '0;
          end else if (w_is_zero) begin
            w_cnt     = '0;
          end
          w_state = (w_cnt != '0) ? SHIFT : ROUND;
        end
      end
      SHIFT: begin
        if (r_left) begin
          w_mag = r_mag << 1;
        end else begin
          w_mag    = {1'b0, r_mag[MAG_W-1:1]};
          w_guard  = r_mag[0];
          w_sticky = r_sticky | r_guard;
        end
        w_cnt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state = ROUND;
      end
      ROUND: begin
        w_state = DONE;
        if (r_inv_pre) begin
          w_data = '0;
          w_inv  = 1'b1;
        end else if (r_sat_pre) begin
          w_data = r_sign ? 16'h8000 : 16'h7FFF;
          w_sat  = 1'b1;
        end else begin
          w_inexact = r_guard | r_sticky;
          if (!r_sign && (w_rnd >= RND_W'(32768))) begin
            w_data = 16'h7FFF;
            w_sat  = 1'b1;
          end else if (r_sign) begin
            w_data = w_neg[DATA_W-1:0];
          end else begin
            w_data = w_rnd[DATA_W-1:0];
          end
        end
      end
      DONE: begin
        if (out_ready) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase

    w_in_ready  = (w_state == IDLE);
    w_out_valid = (w_state == DONE);
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_data;
  assign out_sat     = r_sat;
  assign out_invalid = r_inv;
  assign out_inexact = r_inexact;

endmodule

// File: doc/fp16_to_int16.md
FP16_TO_INT16 -- requirements
Module: fp16_to_int16

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 0, number of fraction bits in the signed fixed-point output (legal 0..14).
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1  in_data holds an FP16 operand.
REQ-005 SHALL have in_ready  output  1  block can accept an operand.
REQ-006 SHALL have in_data  input  16  IEEE-754 binary16 {sign, exp[4:0], man[9:0]}.
REQ-007 SHALL have out_valid  output  1  result registers hold a valid result.
REQ-008 SHALL have out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have out_data  output  16  two's-complement result, Q(15-FRAC_BITS).FRAC_BITS.
REQ-010 SHALL have out_sat  output  1  result saturated (overflow or infinity).
REQ-011 SHALL have out_invalid  output  1  input was NaN.
REQ-012 SHALL have out_inexact  output  1  nonzero bits discarded by rounding.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, ROUND, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-014 SHALL accept on in_valid&in_ready in IDLE and register sign, m={hidden,man} (hidden=0 and E_eff=1 when exp=0, else hidden=1 and E_eff=exp), k=E_eff-25+FRAC_BITS.
REQ-015 SHALL set shift count n=min(|k|,12) for normal-path operands and n=0 for special cases; go to SHIFT if n>0, else to ROUND.
REQ-016 SHALL shift magnitude by one bit per cycle in SHIFT: left when k>0; right when k<0, collecting guard (last bit shifted out) and sticky (OR of all earlier shifted-out bits).
REQ-017 SHALL enter ROUND after the n-th SHIFT cycle, then DONE after exactly one ROUND cycle; out_valid rises n+1 rising edges after the accepting edge.
REQ-018 SHALL round the magnitude to nearest, ties to even (increment if guard&(sticky|lsb)), then negate when sign=1; out_inexact=guard|sticky.
REQ-019 SHALL, with p=E_eff-15+FRAC_BITS, treat p>=16, or p=15 unless sign=1 and man=0, as overflow: out_data=0x7FFF (positive) or 0x8000 (negative), out_sat=1, n=0.
REQ-020 SHALL saturate a positive magnitude of 32768 produced by rounding to 0x7FFF with out_sat=1; negative 32768 yields 0x8000 with out_sat=0.
REQ-021 SHALL map +Inf to 0x7FFF and -Inf to 0x8000, both with out_sat=1; NaN to 0x0000 with out_invalid=1; +/-0 to 0x0000 with all flags 0.
REQ-022 SHALL hold out_data and all flags stable in DONE until out_valid&out_ready, then return to IDLE; no accept in the same cycle as release.
REQ-023 SHALL ignore in_data and in_valid outside IDLE; flags are mutually consistent per result and cleared on every new accept.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-SHIFT, asynchronously force IDLE, in_ready=1 after release, out_valid=0, out_data=0x0000, all flags 0, and discard any in-flight operand.
REQ-025 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-026 SHALL verify, FRAC_BITS=0: 0x3C00 -> 0x0001, out_valid 11 edges after accept, flags 0; 0xC500 -> 0xFFFB.
REQ-027 SHALL verify rounding: 0x3800 -> 0x0000 inexact=1; 0x3E00 -> 0x0002 inexact=1; 0x4100 -> 0x0002 inexact=1; 0x0001 -> 0x0000 inexact=1.
REQ-028 SHALL verify range edges: 0x7800 -> 0x7FFF sat=1, latency 1; 0xF800 -> 0x8000 sat=0; 0x7C00 -> 0x7FFF sat=1; 0xFC00 -> 0x8000 sat=1; 0x7E00 -> 0x0000 invalid=1.
REQ-029 SHALL verify FRAC_BITS=14: 0x3C00 -> 0x4000; 0xBC00 -> 0xC000; 0x4000 -> 0x7FFF sat=1.
REQ-030 SHALL verify backpressure: out_ready low for 5 cycles in DONE keeps out_data stable and in_ready=0; a queued in_valid is accepted only after release.
REQ-031 SHALL verify rst_n pulsed low during SHIFT for 0x3C00 -> out_valid=0 and out_data=0x0000 immediately; the next operand 0x4500 -> 0x0005.
